// File: rtl/fpu_div_arbiter.sv
// fpu_div_arbiter: round-robin front end that shares one combinational
// single-precision divider between NUM_REQ requesters. One operation is in
// flight at a time; operands are held on the divider for DIV_CYCLES cycles
// before the quotient is captured into a valid/ready response tagged with the
// issuing requester's index.
module fpu_div_arbiter #(
    parameter int  NUM_REQ    = 4,
    parameter int  DIV_CYCLES = 3,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [32*NUM_REQ-1:0] req_dividend,
    input  logic [32*NUM_REQ-1:0] req_divisor,
    output logic [31:0]           div_dividend,
    output logic [31:0]           div_divisor,
    input  logic [31:0]           div_quotient,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_quotient,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  rsp_dbz,
    output logic                  busy
);

    // Counter only needs to hold DIV_CYCLES-1.
    localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIV_CYCLES - 1);
    localparam logic [ID_W-1:0]  LAST_RST = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0]  last_gnt_q, last_gnt_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic             dbz_q, dbz_d;
    logic [31:0]      opa_q, opa_d;
    logic [31:0]      opb_q, opb_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_quotient_q, rsp_quotient_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic             rsp_dbz_q, rsp_dbz_d;

    // Search order: cand_idx[0] is the requester right after the last grant.
    logic [ID_W-1:0]  cand_idx [NUM_REQ];
    logic             pick_valid;
    logic [ID_W-1:0]  pick_idx;
    logic [31:0]      pick_dividend;
    logic [31:0]      pick_divisor;
    logic             handshake;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        localparam int OFS = gi + 1;
        assign cand_idx[gi] = (int'(last_gnt_q) + OFS >= NUM_REQ)
                            ? ID_W'(int'(last_gnt_q) + OFS - NUM_REQ)
                            : ID_W'(int'(last_gnt_q) + OFS);
    end

    // Pick the first valid requester in rotated order (lowest k wins).
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[cand_idx[k]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx[k];
            end
        end
    end

    assign pick_dividend = req_dividend[32*int'(pick_idx) +: 32];
    assign pick_divisor  = req_divisor[32*int'(pick_idx) +: 32];

    // Grants are only offered while idle and never during reset.
    assign handshake = (state_q == S_IDLE) && pick_valid && !rst;
    assign req_ready = handshake ? (NUM_REQ'(1) << pick_idx) : '0;

    // Next-state logic for the issue / hold / respond sequence.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        last_gnt_d     = last_gnt_q;
        gnt_id_d       = gnt_id_q;
        dbz_d          = dbz_q;
        opa_d          = opa_q;
        opb_d          = opb_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_quotient_d = rsp_quotient_q;
        rsp_id_d       = rsp_id_q;
        rsp_dbz_d      = rsp_dbz_q;
        case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    opa_d    = pick_dividend;
                    opb_d    = pick_divisor;
                    gnt_id_d = pick_idx;
                    dbz_d    = (pick_divisor[30:0] == 31'd0);
                    cnt_d    = CNT_INIT;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rsp_quotient_d = div_quotient;
                    rsp_id_d       = gnt_id_q;
                    rsp_dbz_d      = dbz_q;
                    rsp_valid_d    = 1'b1;
                    last_gnt_d     = gnt_id_q;
                    state_d        = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State registers; reset abandons any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            last_gnt_q     <= LAST_RST;
            gnt_id_q       <= '0;
            dbz_q          <= 1'b0;
            opa_q          <= '0;
            opb_q          <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_quotient_q <= '0;
            rsp_id_q       <= '0;
            rsp_dbz_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            last_gnt_q     <= last_gnt_d;
            gnt_id_q       <= gnt_id_d;
            dbz_q          <= dbz_d;
            opa_q          <= opa_d;
            opb_q          <= opb_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_quotient_q <= rsp_quotient_d;
            rsp_id_q       <= rsp_id_d;
            rsp_dbz_q      <= rsp_dbz_d;
        end
    end

    assign div_dividend = opa_q;
    assign div_divisor  = opb_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_quotient = rsp_quotient_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_dbz      = rsp_dbz_q;
    assign busy         = (state_q != S_IDLE);

endmodule
